// File: rtl/ddram_arbiter.sv
// ddram_arbiter: shares the byte-wide DDR3 bridge between two clients.
//   Port 0 (General Sound memory) has priority. Port 1 (HPS loader/preload) gets a
//   grant after MAXBURST consecutive port-0 grants made while it was waiting.
//   Only one access is outstanding at a time. A watchdog aborts an access that
//   the bridge never acknowledges.
// Ports:
//   clk_sys, reset                 - system clock, synchronous active-high reset
//   rd*/wr*/addr*/din*             - client requests, held until ack*
//   dout*/ack*                     - client read data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_din - bridge request pulse and held access fields
//   mem_ack/mem_dout               - bridge completion pulse and read data
//   busy                           - an access is in flight
//   timeout_err                    - sticky watchdog abort flag
module ddram_arbiter #(
    parameter int unsigned   AW       = 25,
    parameter logic [AW-1:0] BASE0    = '0,
    parameter logic [AW-1:0] BASE1    = 25'h100000,
    parameter int unsigned   MAXBURST = 4,
    parameter int unsigned   TIMEOUT  = 1023
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          rd0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [7:0]    din0,
    output logic [7:0]    dout0,
    output logic          ack0,

    input  logic          rd1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [7:0]    din1,
    output logic [7:0]    dout1,
    output logic          ack1,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic          mem_ack,
    input  logic [7:0]    mem_dout,

    output logic          busy,
    output logic          timeout_err
);

    localparam int unsigned SW = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAXBURST);
    localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t        state;
    logic          gnt_port;   // port owning the current access
    logic [SW-1:0] starve;
    logic [WW-1:0] wd;

    logic req0, req1, pick1;

    assign req0  = rd0 | wr0;
    assign req1  = rd1 | wr1;
    // Port 1 wins when alone, or when port 0 has used up its burst allowance.
    assign pick1 = req1 & (~req0 | (starve == STARVE_MAX));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= StIdle;
            gnt_port    <= 1'b0;
            starve      <= '0;
            wd          <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            dout0       <= '0;
            dout1       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Pulse outputs default low.
            mem_req <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        gnt_port <= pick1;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        state    <= StIssue;
                        if (pick1) begin
                            mem_addr <= addr1 + BASE1;
                            mem_din  <= din1;
                            mem_we   <= wr1;
                        end else begin
                            mem_addr <= addr0 + BASE0;
                            mem_din  <= din0;
                            mem_we   <= wr0;
                        end
                    end
                    if (!req1 || pick1) begin
                        starve <= '0;
                    end else if (req0 && starve != STARVE_MAX) begin
                        starve <= starve + SW'(1);
                    end
                end

                StIssue: begin
                    wd    <= '0;
                    state <= StWait;
                end

                StWait: begin
                    if (mem_ack || wd == WD_MAX) begin
                        if (!mem_we) begin
                            // An aborted read returns all-ones.
                            if (gnt_port) dout1 <= mem_ack ? mem_dout : 8'hFF;
                            else          dout0 <= mem_ack ? mem_dout : 8'hFF;
                        end
                        if (!mem_ack) timeout_err <= 1'b1;
                        if (gnt_port) ack1 <= 1'b1;
                        else          ack0 <= 1'b1;
                        state <= StDone;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end

                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_arbiter.sv
module tb_ddram_arbiter;

    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          rd0, wr0, rd1, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0]    din0, din1;
    logic [7:0]    dout0, dout1;
    logic          ack0, ack1;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din, mem_dout;
    logic          busy, timeout_err;

    // Second instance with BASE0=1 for the address wrap case.
    logic          w_rd0, w_wr0, w_mem_ack;
    logic [AW-1:0] w_addr0;
    logic [7:0]    w_din0;
    logic [7:0]    w_dout0, w_dout1;
    logic          w_ack0, w_ack1;
    logic          w_mem_req, w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [7:0]    w_mem_din;
    logic          w_busy, w_timeout_err;

    always #5 clk_sys = ~clk_sys;

    ddram_arbiter u_dut (
        .clk_sys(clk_sys), .reset(reset),
        .rd0(rd0), .wr0(wr0), .addr0(addr0), .din0(din0), .dout0(dout0), .ack0(ack0),
        .rd1(rd1), .wr1(wr1), .addr1(addr1), .din1(din1), .dout1(dout1), .ack1(ack1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_ack(mem_ack), .mem_dout(mem_dout),
        .busy(busy), .timeout_err(timeout_err)
    );

    ddram_arbiter #(.BASE0(25'h1)) u_dut_wrap (
        .clk_sys(clk_sys), .reset(reset),
        .rd0(w_rd0), .wr0(w_wr0), .addr0(w_addr0), .din0(w_din0), .dout0(w_dout0),
        .ack0(w_ack0),
        .rd1(1'b0), .wr1(1'b0), .addr1('0), .din1(8'h00), .dout1(w_dout1), .ack1(w_ack1),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_din(w_mem_din),
        .mem_ack(w_mem_ack), .mem_dout(8'h00),
        .busy(w_busy), .timeout_err(w_timeout_err)
    );

    typedef struct packed {
        logic          port;
        logic [AW-1:0] maddr;
        logic          we;
        logic [7:0]    din;
        logic [7:0]    dout;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_dout [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: the bridge memory returns low address byte + 8'h37.
    task automatic push_exp(input bit port, input bit wr, input logic [AW-1:0] addr,
                            input logic [7:0] din, input bit abort);
        exp_t e;
        e.port  = port;
        e.maddr = addr + (port ? 25'h100000 : 25'h0);
        e.we    = wr;
        e.din   = din;
        if (wr)         e.dout = model_dout[port];
        else if (abort) e.dout = 8'hFF;
        else            e.dout = e.maddr[7:0] + 8'h37;
        model_dout[port] = e.dout;
        exp_q.push_back(e);
    endtask

    // Bridge model.
    bit   bridge_on  = 1'b1;
    int   bridge_lat = 3;
    int   late_tok   = 0;
    int   late_done  = 0;
    int   req_cnt    = 0;
    int   req_cyc    = 0;

    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
            if (late_tok != late_done) begin
                late_done = late_tok;
                mem_dout  = 8'h99;
                mem_ack   = 1'b1;
            end else if (mem_req) begin
                req_cnt++;
                req_cyc = cyc;
                if (bridge_on) begin
                    repeat (bridge_lat) @(posedge clk_sys);
                    #1;
                    mem_dout = mem_addr[7:0] + 8'h37;
                    mem_ack  = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every client ack.
    logic prev_req = 1'b0, prev_ack0 = 1'b0, prev_ack1 = 1'b0;
    int   last_ack_cyc = 0;
    exp_t me;

    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if (mem_req) check_eq("mem_req_gap", prev_req, 0);
                if (ack0)    check_eq("ack0_pulse", prev_ack0, 0);
                if (ack1)    check_eq("ack1_pulse", prev_ack1, 0);
                if (ack0 || ack1) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_ack", {ack1, ack0}, 0);
                    end else begin
                        me = exp_q.pop_front();
                        last_ack_cyc = cyc;
                        check_eq("ack_port", {ack1, ack0}, me.port ? 2'b10 : 2'b01);
                        check_eq("mem_addr", mem_addr, me.maddr);
                        check_eq("mem_we", mem_we, me.we);
                        if (me.we) check_eq("mem_din", mem_din, me.din);
                        check_eq("dout", me.port ? dout1 : dout0, me.dout);
                    end
                end
            end
            prev_req  = mem_req;
            prev_ack0 = ack0;
            prev_ack1 = ack1;
        end
    end

    task automatic do_access(input bit port, input bit rd, input bit wr,
                             input logic [AW-1:0] addr, input logic [7:0] din, input bit abort);
        bit got = 1'b0;
        push_exp(port, wr, addr, din, abort);
        if (port) begin rd1 = rd; wr1 = wr; addr1 = addr; din1 = din; end
        else      begin rd0 = rd; wr0 = wr; addr0 = addr; din0 = din; end
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk_sys);
            if (port ? ack1 : ack0) got = 1'b1;
        end
        @(posedge clk_sys);
        #1;
        if (port) begin rd1 = 1'b0; wr1 = 1'b0; end
        else      begin rd0 = 1'b0; wr0 = 1'b0; end
        check_eq("ack_wait", got, 1);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_mem_req"}, mem_req, 0);
        check_eq({pfx, "_mem_we"}, mem_we, 0);
        check_eq({pfx, "_mem_addr"}, mem_addr, 0);
        check_eq({pfx, "_mem_din"}, mem_din, 0);
        check_eq({pfx, "_acks"}, {ack1, ack0}, 0);
        check_eq({pfx, "_dout0"}, dout0, 0);
        check_eq({pfx, "_dout1"}, dout1, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        bit got;
        int n;
        int snap;

        reset = 1'b1;
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
        w_rd0 = 0; w_wr0 = 0; w_addr0 = '0; w_din0 = '0; w_mem_ack = 0;
        model_dout[0] = 8'h00;
        model_dout[1] = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1;
        check_all_zero("rst");
        reset = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;

        // Port-0 read, bridge latency 3.
        bridge_lat = 3;
        do_access(0, 1, 0, 25'h00123, 8'h00, 0);
        check_eq("t1_dout0", dout0, 8'h5A);

        // Port-1 read then write; the write leaves dout1 alone.
        do_access(1, 1, 0, 25'h00020, 8'h00, 0);
        do_access(1, 0, 1, 25'h00010, 8'hC3, 0);
        check_eq("t2_dout1", dout1, 8'h57);

        // Both ports held: 0,0,0,0,1 repeating.
        bridge_lat = 1;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) push_exp(1, 0, 25'h00080, 8'h00, 0);
            else            push_exp(0, 0, 25'h00040, 8'h00, 0);
        end
        addr0 = 25'h00040; addr1 = 25'h00080;
        rd0 = 1'b1; rd1 = 1'b1;
        n = 0;
        for (int i = 0; i < 400 && n < 10; i++) begin
            @(negedge clk_sys);
            if (ack0 || ack1) n++;
        end
        @(posedge clk_sys);
        #1;
        rd0 = 1'b0; rd1 = 1'b0;
        check_eq("arb_acks", n, 10);
        repeat (8) @(posedge clk_sys);
        #1;
        check_eq("arb_q_empty", exp_q.size(), 0);
        check_eq("arb_busy", busy, 0);

        // Watchdog abort on a port-0 read.
        check_eq("pre_timeout_err", timeout_err, 0);
        bridge_on = 1'b0;
        do_access(0, 1, 0, 25'h00077, 8'h00, 1);
        check_eq("to_latency", last_ack_cyc - req_cyc, 1025);
        check_eq("to_err", timeout_err, 1);
        check_eq("to_dout0", dout0, 8'hFF);
        late_tok++;
        repeat (4) @(posedge clk_sys);
        #1;
        check_eq("late_dout0", dout0, 8'hFF);
        check_eq("late_busy", busy, 0);
        check_eq("late_err", timeout_err, 1);
        bridge_on = 1'b1;

        // Reset while waiting on the bridge.
        bridge_lat = 6;
        addr1 = 25'h00030;
        rd1 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_sys);
            if (mem_req) got = 1'b1;
        end
        check_eq("rw_req_seen", got, 1);
        repeat (2) @(posedge clk_sys);
        #1;
        check_eq("rw_busy", busy, 1);
        reset = 1'b1;
        rd1 = 1'b0;
        @(posedge clk_sys);
        #1;
        check_all_zero("rw");
        reset = 1'b0;
        model_dout[0] = 8'h00;
        model_dout[1] = 8'h00;
        snap = req_cnt;
        repeat (10) @(posedge clk_sys);
        #1;
        check_eq("rw_no_reissue", req_cnt, snap);
        check_eq("rw_dout1", dout1, 0);
        check_eq("rw_idle", busy, 0);

        // rd+wr together on the wrap instance: write to address 0.
        w_rd0 = 1'b1; w_wr0 = 1'b1; w_addr0 = '1; w_din0 = 8'h3C;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_sys);
            if (w_mem_req) got = 1'b1;
        end
        check_eq("wrap_req", got, 1);
        check_eq("wrap_addr", w_mem_addr, 0);
        check_eq("wrap_we", w_mem_we, 1);
        check_eq("wrap_din", w_mem_din, 8'h3C);
        @(posedge clk_sys);
        #1;
        w_rd0 = 1'b0; w_wr0 = 1'b0;
        w_mem_ack = 1'b1;
        @(posedge clk_sys);
        #1;
        w_mem_ack = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_sys);
            if (w_ack0) got = 1'b1;
        end
        check_eq("wrap_ack", got, 1);
        check_eq("wrap_dout0", w_dout0, 0);

        repeat (4) @(posedge clk_sys);
        #1;
        check_eq("final_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
